// File: rtl/alu_pkg.sv
// Shared opcode map, sequencer state encoding and opcode classification helpers.
package alu_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OPC_W-1:0] OP_AND  = 4'b0001;
    localparam logic [OPC_W-1:0] OP_OR   = 4'b0010;
    localparam logic [OPC_W-1:0] OP_NOT  = 4'b0011;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'b0100;
    localparam logic [OPC_W-1:0] OP_DIV  = 4'b0101;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'b0110;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'b1001;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Opcode is one the ALU implements.
    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_AND, OP_OR, OP_NOT, OP_MUL,
            OP_DIV, OP_ADDI, OP_SUB, OP_MOV: legal = 1'b1;
            default:                         legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Opcode needs the ALU valid handshake instead of a fixed one-cycle latency.
    function automatic logic is_multicycle(input logic [OPC_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer around the fixed-point ALU: holds operands stable
// while the ALU runs, captures its result and hands it to writeback.
module alu_issue_seq
    import alu_pkg::*;
#(
    parameter int unsigned N            = 32,
    parameter int unsigned WIDTH_OPCODE = 4,
    parameter int unsigned RD_W         = 5,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH_OPCODE-1:0] in_opcode,
    input  logic [RD_W-1:0]         in_rd,
    input  logic [N-1:0]            in_a,
    input  logic [N-1:0]            in_b,
    input  logic [N-1:0]            in_imm,
    output logic                    alu_enable,
    output logic [WIDTH_OPCODE-1:0] alu_opcode,
    output logic [N-1:0]            alu_a,
    output logic [N-1:0]            alu_b,
    output logic [N-1:0]            alu_imm,
    input  logic                    alu_valid,
    input  logic                    alu_zero,
    input  logic [N-1:0]            alu_data,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [RD_W-1:0]         wb_rd,
    output logic [N-1:0]            wb_data,
    output logic                    wb_zero,
    output logic                    wb_err,
    output logic                    busy
);

    localparam int unsigned         CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic                    r_multi, w_multi_nxt;

    logic                    w_en_nxt;
    logic [WIDTH_OPCODE-1:0] w_opc_nxt;
    logic [N-1:0]            w_a_nxt, w_b_nxt, w_imm_nxt;
    logic                    w_wbv_nxt;
    logic [RD_W-1:0]         w_rd_nxt;
    logic [N-1:0]            w_data_nxt;
    logic                    w_zero_nxt, w_err_nxt;

    logic                    w_legal, w_multi, w_result_ok;

    assign w_legal  = is_legal(OPC_W'(in_opcode));
    assign w_multi  = is_multicycle(OPC_W'(in_opcode));
    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);

    // First EXEC cycle ignores alu_valid so a stale pulse from the ALU is never taken.
    assign w_result_ok = r_multi ? (alu_valid && (r_cnt != '0)) : 1'b1;

    // Next-state and next-register values.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_multi_nxt = r_multi;
        w_en_nxt    = alu_enable;
        w_opc_nxt   = alu_opcode;
        w_a_nxt     = alu_a;
        w_b_nxt     = alu_b;
        w_imm_nxt   = alu_imm;
        w_wbv_nxt   = wb_valid;
        w_rd_nxt    = wb_rd;
        w_data_nxt  = wb_data;
        w_zero_nxt  = wb_zero;
        w_err_nxt   = wb_err;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_opc_nxt   = in_opcode;
                    w_a_nxt     = in_a;
                    w_b_nxt     = in_b;
                    w_imm_nxt   = in_imm;
                    w_rd_nxt    = in_rd;
                    w_cnt_nxt   = '0;
                    w_multi_nxt = w_multi;
                    if (w_legal) begin
                        w_state_nxt = EXEC;
                        w_en_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                        w_wbv_nxt   = 1'b1;
                        w_data_nxt  = '0;
                        w_zero_nxt  = 1'b0;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            EXEC: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_result_ok) begin
                    w_state_nxt = DONE;
                    w_en_nxt    = 1'b0;
                    w_wbv_nxt   = 1'b1;
                    w_data_nxt  = alu_data;
                    w_zero_nxt  = alu_zero;
                    w_err_nxt   = 1'b0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DONE;
                    w_en_nxt    = 1'b0;
                    w_wbv_nxt   = 1'b1;
                    w_data_nxt  = '0;
                    w_zero_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                end
            end
            DONE: begin
                if (wb_ready) begin
                    w_state_nxt = IDLE;
                    w_wbv_nxt   = 1'b0;
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_en_nxt    = 1'b0;
                w_wbv_nxt   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_multi    <= 1'b0;
            alu_enable <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_imm    <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_zero    <= 1'b0;
            wb_err     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_multi    <= w_multi_nxt;
            alu_enable <= w_en_nxt;
            alu_opcode <= w_opc_nxt;
            alu_a      <= w_a_nxt;
            alu_b      <= w_b_nxt;
            alu_imm    <= w_imm_nxt;
            wb_valid   <= w_wbv_nxt;
            wb_rd      <= w_rd_nxt;
            wb_data    <= w_data_nxt;
            wb_zero    <= w_zero_nxt;
            wb_err     <= w_err_nxt;
        end
    end

endmodule

// File: doc/alu_issue_seq.md
Name: alu_issue_seq

Overview:
- Issue/writeback sequencer directly upstream and downstream of the fixed-point ALU (Q16.16 by default).
- Accepts one decoded operation with operands, drives the ALU's enable, opcode and operand inputs, and holds them stable while the operation runs.
- Waits for the ALU valid (1 cycle for logic/add ops, multi-cycle for mul/div), then presents the captured result to the register-file writeback through a valid/ready handshake.
- Guards against unknown opcodes and divider/multiplier hangs.

Parameters:
- N, 32, datapath width (matches ALU N).
- WIDTH_OPCODE, 4, opcode width.
- RD_W, 5, destination register index width.
- TIMEOUT, 64, max EXEC cycles for a multi-cycle op before abort (>=2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  sequencer can accept an op.
- in_opcode  in  WIDTH_OPCODE  ALU opcode.
- in_rd  in  RD_W  destination register.
- in_a, in_b, in_imm  in  N each  operand A, operand B, immediate (signed).
- alu_enable  out  1  to ALU enable_alu.
- alu_opcode  out  WIDTH_OPCODE  to ALU.
- alu_a, alu_b, alu_imm  out  N each  to ALU dataA/dataB/data_imm.
- alu_valid  in  1  ALU valid.
- alu_zero  in  1  ALU zero flag.
- alu_data  in  N  ALU data_out.
- wb_valid  out  1  result valid.
- wb_ready  in  1  writeback accepts.
- wb_rd  out  RD_W  destination register.
- wb_data  out  N  result.
- wb_zero  out  1  result == 0.
- wb_err  out  1  illegal opcode or timeout.
- busy  out  1  state != IDLE.

Behaviour:
- Opcode classes:
  - Single-cycle, legal: 0000 add, 0001 and, 0010 or, 0011 not, 0110 addi, 1001 sub, 1011 mov.
  - Multi-cycle, legal: 0100 mul, 0101 div.
  - Anything else is illegal.
- States: IDLE, EXEC, DONE; state register uses async reset to IDLE.
- Reset values:
  - All registered outputs 0 (alu_enable, alu_* operands, wb_valid, wb_rd, wb_data, wb_zero, wb_err); timeout counter 0.
  - in_ready = (state==IDLE), so it reads 1 while rst is asserted and after release.
- IDLE:
  - On in_valid&&in_ready at edge k, latch opcode, rd, a, b, imm into the alu_* and rd registers.
  - Legal opcode -> EXEC, with alu_enable=1 from cycle k+1.
  - Illegal opcode -> DONE directly: wb_err=1, wb_data=0, wb_zero=0, alu_enable stays 0.
- EXEC:
  - alu_enable and all alu_* inputs are held constant for the whole state.
  - Single-cycle op: alu_data/alu_zero captured at end of cycle k+1 regardless of alu_valid; go DONE; wb_valid=1 from cycle k+2.
  - Multi-cycle op: alu_valid is ignored in the first EXEC cycle (k+1) and sampled from k+2 onward. If it is seen high in cycle j, capture data/zero and wb_valid=1 from j+1.
  - Counter increments every EXEC cycle. If TIMEOUT EXEC cycles pass with no accepted alu_valid, go DONE with wb_err=1, wb_data=0, wb_zero=0.
  - alu_enable drops to 0 on leaving EXEC.
  - alu_valid high on the same cycle the counter reaches TIMEOUT: the valid wins, err=0.
- DONE:
  - wb_valid=1; wb_rd/data/zero/err held stable until wb_valid&&wb_ready.
  - After the handshake, go IDLE: wb_valid=0 next cycle, wb_err cleared, counter cleared.
- in_ready is 0 in EXEC and DONE. There is no bypass, so sustained throughput is one single-cycle op per 3 cycles.
- alu_valid outside EXEC is ignored.
- wb_ready while wb_valid=0 has no effect.
- in_valid while in_ready=0 does not latch; upstream must hold the op.
- rst asserted mid-operation: immediate return to IDLE, alu_enable=0, wb_valid=0, the op is dropped with no writeback; the ALU unit is reset on the same rst.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD, OP_AND, OP_OR, OP_NOT, OP_MUL, OP_DIV, OP_ADDI, OP_SUB, OP_MOV);
  - state enum {IDLE, EXEC, DONE};
  - functions is_legal(op) and is_multicycle(op).
- The ALU also imports alu_pkg.
- No sub-module; the timeout counter stays inline.

Test Plan:
- add: a=0x00010000, b=0x00020000, handshake at edge 0 -> wb_valid from cycle 2, wb_data=0x00030000, wb_zero=0, wb_err=0, wb_rd=in_rd.
- sub: a=b=0x00050000 -> wb_data=0, wb_zero=1. Back-to-back ops with in_valid held -> second accepted exactly 3 cycles after the first.
- mul: a=0x00018000 (1.5), b=0x00020000 (2.0), model alu_valid after 4 cycles; also a stale alu_valid pulse in the first EXEC cycle -> pulse ignored, wb_data=0x00030000 one cycle after the real valid.
- Illegal opcode 0111 -> alu_enable never asserts, wb_valid at cycle 1, wb_err=1, wb_data=0.
- div with alu_valid held low, TIMEOUT=8 -> wb_err=1 after 8 EXEC cycles, alu_enable low thereafter. Repeat with valid on the 8th cycle -> err=0, data captured.
- Hold wb_ready low 5 cycles in DONE -> wb outputs stable, in_ready=0. Separately, assert rst during mul EXEC -> alu_enable and wb_valid drop immediately, in_ready=1, no writeback.
